// File: rtl/fp_add_arbiter.sv
// Round-robin front end that time-shares one combinational floating adder.
// Operands are registered onto the adder, and the sum is returned over valid/ready.
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int CNTW    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  input  logic [31:0]           add_out,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           rsp_data,
  input  logic                  rsp_ready,
  output logic                  busy,
  output logic [CNTW-1:0]       op_count
);

  // state | meaning
  // IDLE  | arbitrate; accept one request and load the adder operands
  // EXEC  | adder settling; sum captured at the end of this cycle
  // RESP  | result presented until the consumer takes it
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [31:0]     add_a_q, add_a_d;
  logic [31:0]     add_b_q, add_b_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic [CNTW-1:0] op_count_q, op_count_d;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  idx;
  logic [31:0]     sel_a, sel_b;

  // Search starts at rr_ptr and wraps, so the last winner goes to the back.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    op_count_d = op_count_q;
    req_ready  = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = rst_n && (grant_idx == IDW'(i));
          end
          add_a_d  = sel_a;
          add_b_d  = sel_b;
          rsp_id_d = grant_idx;
          rr_ptr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = add_out;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (op_count_q != '1) op_count_d = op_count_q + CNTW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      op_count_q <= op_count_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign op_count  = op_count_q;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a lookup-table stand-in for the adder.
// A narrow op counter is used so saturation is reachable in a short run.
module tb_fp_add_arbiter;
  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;
  localparam int CNTW    = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_a, req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           add_a, add_b, add_out;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_data;
  logic                  rsp_ready;
  logic                  busy;
  logic [CNTW-1:0]       op_count;

  logic [31:0] op_a [NUM_REQ];
  logic [31:0] op_b [NUM_REQ];
  int          errors = 0;
  int          checks = 0;
  int          exp_cnt = 0;

  fp_add_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_out(add_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[32*i +: 32] = op_a[i];
      req_b[32*i +: 32] = op_b[i];
    end
  end

  // Hand-computed IEEE-754 single sums for every operand pair used below.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F000000, 32'h3F000000}: return 32'h3F800000;
      {32'h3FC00000, 32'h40200000}: return 32'h40800000;
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h40800000, 32'h40800000}: return 32'h41000000;
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h00000000, 32'h00000000}: return 32'h00000000;
      {32'hBF800000, 32'h3F800000}: return 32'h00000000;
      {32'h40400000, 32'h3F800000}: return 32'h40800000;
      default:                      return 32'hFFC00000;
    endcase
  endfunction

  assign add_out = fadd(add_a, add_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic raise(input int id, input logic [31:0] a, input logic [31:0] b);
    op_a[id] = a;
    op_b[id] = b;
    req_valid[id] = 1'b1;
  endtask

  // Called at a negedge with requests already driven and DUT idle or about to be.
  task automatic run_op(input int id, input logic [31:0] exp_data);
    logic [31:0] ea, eb;
    bit seen = 0;
    for (int w = 0; w < 8 && !seen; w++) begin
      #1;
      if (req_ready != '0) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL grant_timeout: got none expected id %0d", id);
      return;
    end
    chk("grant_onehot", 32'(req_ready), 32'(1 << id));
    ea = op_a[id];
    eb = op_b[id];
    @(negedge clk);
    req_valid[id] = 1'b0;
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_req_ready", 32'(req_ready), 32'd0);
    chk("exec_add_a", add_a, ea);
    chk("exec_add_b", add_b, eb);
    @(negedge clk);
    chk("resp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_id", 32'(rsp_id), 32'(id));
    chk("resp_data", rsp_data, exp_data);
    chk("resp_add_a_hold", add_a, ea);
    @(negedge clk);
    if (exp_cnt < (1 << CNTW) - 1) exp_cnt++;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("op_count", 32'(op_count), 32'(exp_cnt));
  endtask

  typedef struct {
    logic [3:0]   raise;
    logic [127:0] a;
    logic [127:0] b;
    int           id;
    logic [31:0]  data;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{4'b1111, {32'h40800000, 32'h3F800000, 32'h3FC00000, 32'h3F000000},
                         {32'h40800000, 32'h40000000, 32'h40200000, 32'h3F000000}, 0, 32'h3F800000};
    vecs[1] = '{4'b0000, 128'd0, 128'd0, 1, 32'h40800000};
    vecs[2] = '{4'b0000, 128'd0, 128'd0, 2, 32'h40400000};
    vecs[3] = '{4'b0000, 128'd0, 128'd0, 3, 32'h41000000};
    vecs[4] = '{4'b0001, {96'd0, 32'h3F800000}, {96'd0, 32'h3F800000}, 0, 32'h40000000};
    vecs[5] = '{4'b0100, 128'd0, 128'd0, 2, 32'h00000000};
    vecs[6] = '{4'b1001, {32'hBF800000, 64'd0, 32'h40400000},
                         {32'h3F800000, 64'd0, 32'h3F800000}, 3, 32'h00000000};
    vecs[7] = '{4'b0000, 128'd0, 128'd0, 0, 32'h40800000};

    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = 32'h3F800000;
      op_b[i] = 32'h3F800000;
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req", 32'(req_ready), 32'd0);

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (vecs[v].raise[i]) raise(i, vecs[v].a[32*i +: 32], vecs[v].b[32*i +: 32]);
      run_op(vecs[v].id, vecs[v].data);
    end

    // Backpressure, plus a requester withdrawing before it is granted.
    rsp_ready = 1'b0;
    raise(0, 32'h3F800000, 32'h3F800000);
    #1 chk("bp_grant", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid[0] = 1'b0;
    raise(1, 32'h3F000000, 32'h3F000000);
    raise(2, 32'h3F800000, 32'h40000000);
    #1 chk("bp_exec_no_grant", 32'(req_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) req_valid[1] = 1'b0;
      #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_data", rsp_data, 32'h40000000);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
      chk("bp_count", 32'(op_count), 32'(exp_cnt));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    chk("bp_release_count", 32'(op_count), 32'(exp_cnt));
    run_op(2, 32'h40400000);

    // Drive the counter past its all-ones value.
    for (int n = 0; n < 8; n++) begin
      raise(1, 32'h00000000, 32'h00000000);
      run_op(1, 32'h00000000);
    end
    chk("sat_count", 32'(op_count), 32'hF);

    // Reset while the adder is evaluating.
    raise(3, 32'h3F800000, 32'h40000000);
    #1 chk("mid_grant", 32'(req_ready), 32'b1000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_op_count", 32'(op_count), 32'd0);
    chk("mid_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    raise(1, 32'h3F000000, 32'h3F000000);
    raise(0, 32'h3FC00000, 32'h40200000);
    run_op(0, 32'h40800000);
    run_op(1, 32'h3F800000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
